// File: rtl/vga_text_console_pkg.sv
// Shared types and constants for the VGA text console: ASCII control codes,
// console FSM states, cursor types and the bus word types.
package vga_text_console_pkg;

    typedef logic        bit_t;
    typedef logic [31:0] word_t;
    typedef logic [7:0]  ascii_t;
    typedef logic [7:0]  cursor_t;

    typedef struct packed {
        cursor_t row;
        cursor_t col;
    } cursor_pos_t;

    localparam ascii_t ASCII_SPACE = 8'h20;
    localparam ascii_t ASCII_CR    = 8'h0D;
    localparam ascii_t ASCII_LF    = 8'h0A;
    localparam ascii_t ASCII_BS    = 8'h08;
    localparam ascii_t ASCII_FF    = 8'h0C;

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_SCREEN
    } console_state_t;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_ADVANCE,
        CUR_CR,
        CUR_LF,
        CUR_BS,
        CUR_HOME
    } cursor_cmd_t;

    function automatic bit_t is_printable(input ascii_t code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/vga_cursor.sv
// Cursor column/row registers: advance with row wrap, CR, LF, backspace and home.
// Exposes the cell index row*COLS+col at full bus width.
module vga_cursor
    import vga_text_console_pkg::*;
#(
    parameter int COLS = 100,
    parameter int ROWS = 37
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  cursor_cmd_t cmd,
    output cursor_pos_t pos,
    output logic        at_last_col,
    output logic        at_first_col,
    output word_t       cell_addr
);

    localparam cursor_t LAST_COL = cursor_t'(COLS - 1);
    localparam cursor_t LAST_ROW = cursor_t'(ROWS - 1);

    cursor_t col_q, col_d;
    cursor_t row_q, row_d;
    cursor_t next_row;

    assign at_last_col  = (col_q == LAST_COL);
    assign at_first_col = (col_q == '0);
    // Ring-style wrap: there is no readback, so the display never scrolls.
    assign next_row     = (row_q == LAST_ROW) ? '0 : row_q + 8'd1;
    assign cell_addr    = word_t'(row_q) * word_t'(COLS) + word_t'(col_q);
    assign pos          = '{row: row_q, col: col_q};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        col_d = col_q;
        row_d = row_q;
        case (cmd)
            CUR_ADVANCE: begin
                if (at_last_col) begin
                    col_d = '0;
                    row_d = next_row;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end
            CUR_CR:   col_d = '0;
            CUR_LF: begin
                col_d = '0;
                row_d = next_row;
            end
            CUR_BS: begin
                if (!at_first_col) col_d = col_q - 8'd1;
            end
            CUR_HOME: begin
                col_d = '0;
                row_d = '0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/vga_text_console.sv
// Character-stream front end for the VGA text display: byte handshake, control-code
// decode, line/screen clear sequencer and registered one-cycle cell-write strobes.
module vga_text_console
    import vga_text_console_pkg::*;
#(
    parameter int COLS       = 100,
    parameter int ROWS       = 37,
    parameter int INIT_CLEAR = 1
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        write_op,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_data,
    output logic [7:0]  cursor_col,
    output logic [7:0]  cursor_row,
    output logic        busy
);

    localparam int CELLS = COLS * ROWS;
    localparam int CNT_W = $clog2(CELLS);

    typedef logic [CNT_W-1:0] clr_cnt_t;

    localparam clr_cnt_t       LINE_LAST   = clr_cnt_t'(COLS - 1);
    localparam clr_cnt_t       SCREEN_LAST = clr_cnt_t'(CELLS - 1);
    localparam console_state_t RESET_STATE = (INIT_CLEAR != 0) ? CLR_SCREEN : IDLE;

    console_state_t state_q, state_d;
    clr_cnt_t       clr_cnt_q, clr_cnt_d;
    bit_t           clr_done_q, clr_done_d;
    bit_t           write_op_q, write_op_d;
    word_t          bus_addr_q, bus_addr_d;
    word_t          bus_data_q, bus_data_d;
    bit_t           char_ready_q, char_ready_d;
    bit_t           busy_q, busy_d;

    cursor_cmd_t    cursor_cmd;
    cursor_pos_t    cursor_pos;
    logic           at_last_col;
    logic           at_first_col;
    word_t          cell_addr;
    logic           accept;
    clr_cnt_t       clr_last;

    vga_cursor #(
        .COLS(COLS),
        .ROWS(ROWS)
    ) u_cursor (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .cmd         (cursor_cmd),
        .pos         (cursor_pos),
        .at_last_col (at_last_col),
        .at_first_col(at_first_col),
        .cell_addr   (cell_addr)
    );

    assign accept   = char_valid && char_ready_q;
    assign clr_last = (state_q == CLR_LINE) ? LINE_LAST : SCREEN_LAST;

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done_d = clr_done_q;
        write_op_d = 1'b0;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        cursor_cmd = CUR_HOLD;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_printable(char_data)) begin
                        write_op_d = 1'b1;
                        bus_addr_d = cell_addr;
                        bus_data_d = {24'b0, char_data};
                        cursor_cmd = CUR_ADVANCE;
                        // The character write goes out now; the new row's clear follows.
                        if (at_last_col) begin
                            state_d   = CLR_LINE;
                            clr_cnt_d = '0;
                        end
                    end else begin
                        case (char_data)
                            ASCII_CR: cursor_cmd = CUR_CR;
                            ASCII_LF: begin
                                cursor_cmd = CUR_LF;
                                state_d    = CLR_LINE;
                                clr_cnt_d  = '0;
                            end
                            ASCII_BS: begin
                                if (!at_first_col) begin
                                    cursor_cmd = CUR_BS;
                                    write_op_d = 1'b1;
                                    bus_addr_d = cell_addr - 32'd1;
                                    bus_data_d = {24'b0, ASCII_SPACE};
                                end
                            end
                            ASCII_FF: begin
                                cursor_cmd = CUR_HOME;
                                state_d    = CLR_SCREEN;
                                clr_cnt_d  = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            CLR_LINE, CLR_SCREEN: begin
                // One idle cycle after the last write keeps ready low across every clear pulse.
                if (clr_done_q) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b0;
                end else begin
                    write_op_d = 1'b1;
                    bus_data_d = {24'b0, ASCII_SPACE};
                    bus_addr_d = (state_q == CLR_LINE) ? cell_addr + word_t'(clr_cnt_q)
                                                       : word_t'(clr_cnt_q);
                    if (clr_cnt_q == clr_last) begin
                        clr_cnt_d  = '0;
                        clr_done_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + clr_cnt_t'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        char_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            clr_cnt_q    <= '0;
            clr_done_q   <= 1'b0;
            write_op_q   <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            char_ready_q <= (RESET_STATE == IDLE);
            busy_q       <= (RESET_STATE != IDLE);
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_done_q   <= clr_done_d;
            write_op_q   <= write_op_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign char_ready = char_ready_q;
    assign write_op   = write_op_q;
    assign bus_addr   = bus_addr_q;
    assign bus_data   = bus_data_q;
    assign busy       = busy_q;
    assign cursor_col = cursor_pos.col;
    assign cursor_row = cursor_pos.row;

endmodule

// File: tb/tb_vga_text_console.sv
// Directed bench for vga_text_console (COLS=100, ROWS=37, INIT_CLEAR=1): a negedge
// monitor logs every write with a cycle stamp; steps compare against hand-derived values.
module tb_vga_text_console;

    logic        clk_50M = 1'b0;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        write_op;
    logic [31:0] bus_addr;
    logic [31:0] bus_data;
    logic [7:0]  cursor_col;
    logic [7:0]  cursor_row;
    logic        busy;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t wq[$];
    int  ncyc  = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  low_cycles;
    int  busy_bad;
    int  snap;

    vga_text_console #(
        .COLS      (100),
        .ROWS      (37),
        .INIT_CLEAR(1)
    ) dut (
        .clk_50M   (clk_50M),
        .rst       (rst),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .write_op  (write_op),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row),
        .busy      (busy)
    );

    always #10 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        ncyc++;
        if (write_op === 1'b1)
            wq.push_back('{addr: bus_addr, data: bus_data, cyc: ncyc});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs read 1 time unit after the falling edge.
    task automatic step();
        @(negedge clk_50M);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        for (int i = 0; i < 5000 && char_ready !== 1'b1; i++) step();
        char_valid = 1'b1;
        char_data  = b;
        step();
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output int low, output int bad);
        low = 0;
        bad = 0;
        for (int i = 0; i < max_cycles; i++) begin
            step();
            if (char_ready === 1'b1) break;
            low++;
            if (busy !== 1'b1) bad++;
        end
        check("idle_reached", char_ready, 1);
    endtask

    function automatic wr_t rec(input int i);
        wr_t r;
        r.addr = '1;
        r.data = '1;
        r.cyc  = -1;
        if (i >= 0 && i < wq.size()) r = wq[i];
        return r;
    endfunction

    // Counts entries that break an ascending, gap-free run of space writes from base.
    function automatic int run_errs(input int first, input int n, input logic [31:0] base);
        int  e;
        wr_t r0;
        wr_t r;
        e  = 0;
        r0 = rec(first);
        for (int i = 0; i < n; i++) begin
            r = rec(first + i);
            if (r.addr !== base + i || r.data !== 32'h20 || r.cyc != r0.cyc + i) e++;
        end
        return e;
    endfunction

    initial begin
        rst        = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        repeat (3) step();

        // Reset values while held in reset.
        check("rst_write_op", write_op, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_data", bus_data, 0);
        check("rst_cursor_col", cursor_col, 0);
        check("rst_cursor_row", cursor_row, 0);
        check("rst_char_ready", char_ready, 0);
        check("rst_busy", busy, 1);

        // Power-on clear of all 3700 cells.
        rst = 1'b0;
        wq.delete();
        wait_idle(5000, low_cycles, busy_bad);
        check("init_clr_count", wq.size(), 3700);
        check("init_clr_run_errs", run_errs(0, 3700, 0), 0);
        check("init_clr_ready_low", low_cycles, 3700);
        check("init_clr_busy_bad", busy_bad, 0);
        check("init_cursor_col", cursor_col, 0);
        check("init_cursor_row", cursor_row, 0);
        check("init_busy_idle", busy, 0);

        // Back-to-back 'A','B' with no bubble.
        wq.delete();
        char_valid = 1'b1;
        char_data  = 8'h41;
        step();
        char_data  = 8'h42;
        step();
        char_valid = 1'b0;
        step();
        check("ab_count", wq.size(), 2);
        check("a_addr", rec(0).addr, 0);
        check("a_data", rec(0).data, 32'h41);
        check("b_addr", rec(1).addr, 1);
        check("b_data", rec(1).data, 32'h42);
        check("ab_gap", rec(1).cyc - rec(0).cyc, 1);
        check("ab_cursor_col", cursor_col, 2);
        check("ab_cursor_row", cursor_row, 0);

        // Walk to (36,99): 36 line feeds then 99 printables.
        for (int i = 0; i < 36; i++) begin
            send(8'h0A);
            wait_idle(300, low_cycles, busy_bad);
        end
        for (int i = 0; i < 99; i++) send(8'h78);
        check("pre_wrap_col", cursor_col, 99);
        check("pre_wrap_row", cursor_row, 36);

        // 'Z' in the last cell: its write first, then the clear of row 0.
        wq.delete();
        send(8'h5A);
        wait_idle(300, low_cycles, busy_bad);
        check("wrap_count", wq.size(), 101);
        check("wrap_z_addr", rec(0).addr, 3699);
        check("wrap_z_data", rec(0).data, 32'h5A);
        check("wrap_clr_gap", rec(1).cyc - rec(0).cyc, 1);
        check("wrap_clr_run_errs", run_errs(1, 100, 0), 0);
        check("wrap_ready_low", low_cycles, 100);
        check("wrap_busy_bad", busy_bad, 0);
        check("wrap_cursor_col", cursor_col, 0);
        check("wrap_cursor_row", cursor_row, 0);

        // Backspace at (3,5) and at (3,0).
        for (int i = 0; i < 3; i++) begin
            send(8'h0A);
            wait_idle(300, low_cycles, busy_bad);
        end
        for (int i = 0; i < 5; i++) send(8'h61);
        wq.delete();
        send(8'h08);
        step();
        step();
        check("bs_count", wq.size(), 1);
        check("bs_addr", rec(0).addr, 304);
        check("bs_data", rec(0).data, 32'h20);
        check("bs_cursor_col", cursor_col, 4);
        check("bs_cursor_row", cursor_row, 3);
        send(8'h0D);
        step();
        wq.delete();
        send(8'h08);
        step();
        step();
        check("bs0_count", wq.size(), 0);
        check("bs0_cursor_col", cursor_col, 0);
        check("bs0_cursor_row", cursor_row, 3);

        // LF at (4,7) clears row 5.
        send(8'h0A);
        wait_idle(300, low_cycles, busy_bad);
        for (int i = 0; i < 7; i++) send(8'h61);
        check("pre_lf_col", cursor_col, 7);
        check("pre_lf_row", cursor_row, 4);
        wq.delete();
        send(8'h0A);
        wait_idle(300, low_cycles, busy_bad);
        check("lf_count", wq.size(), 100);
        check("lf_run_errs", run_errs(0, 100, 500), 0);
        check("lf_cursor_col", cursor_col, 0);
        check("lf_cursor_row", cursor_row, 5);

        // CR at (5,9), then codes that are swallowed without a write.
        for (int i = 0; i < 9; i++) send(8'h61);
        wq.delete();
        send(8'h0D);
        step();
        check("cr_count", wq.size(), 0);
        check("cr_cursor_col", cursor_col, 0);
        check("cr_cursor_row", cursor_row, 5);
        send(8'h07);
        check("bel_ready", char_ready, 1);
        send(8'h7F);
        send(8'hC3);
        step();
        check("ignored_count", wq.size(), 0);
        check("ignored_cursor_col", cursor_col, 0);
        send(8'h7E);
        step();
        check("tilde_count", wq.size(), 1);
        check("tilde_addr", rec(0).addr, 500);
        check("tilde_data", rec(0).data, 32'h7E);
        check("tilde_cursor_col", cursor_col, 1);

        // FF, then reset in the middle of the screen clear.
        wq.delete();
        send(8'h0C);
        check("ff_busy", busy, 1);
        check("ff_cursor_col", cursor_col, 0);
        check("ff_cursor_row", cursor_row, 0);
        for (int i = 0; i < 2000 && wq.size() < 1000; i++) step();
        snap = wq.size();
        check("ff_partial_count", snap, 1000);
        check("ff_partial_run_errs", run_errs(0, 1000, 0), 0);
        check("ff_pre_rst_write_op", write_op, 1);
        rst = 1'b1;
        #1;
        check("abort_write_op", write_op, 0);
        check("abort_bus_addr", bus_addr, 0);
        check("abort_bus_data", bus_data, 0);
        check("abort_char_ready", char_ready, 0);
        check("abort_busy", busy, 1);
        step();
        step();
        rst = 1'b0;
        wq.delete();
        wait_idle(5000, low_cycles, busy_bad);
        check("restart_count", wq.size(), 3700);
        check("restart_run_errs", run_errs(0, 3700, 0), 0);
        check("restart_ready_low", low_cycles, 3700);
        check("restart_cursor_col", cursor_col, 0);
        check("restart_cursor_row", cursor_row, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_text_console.md
Name: vga_text_console

Overview:
- Character-stream front end for the VGA text display; drives the display's write interface (write_op/bus_addr/bus_data) with one-cycle write pulses.
- Accepts ASCII bytes over a valid/ready handshake and keeps a cursor.
- Translates printable characters and control codes (CR, LF, BS, FF) into cell writes, including line and screen clears.
- Sits between the CPU/UART character source and vga_controller.

Parameters:
- COLS, 100, text columns (cell grid width; 8-pixel-wide glyphs)
- ROWS, 37, text rows (16-pixel-tall glyphs)
- INIT_CLEAR, 1, when 1, run a full-screen clear after reset

Ports:
- clk_50M  input  1  system/pixel clock; all logic on posedge
- rst  input  1  reset, asynchronous, active-high
- char_valid  input  1  source has a byte on char_data
- char_data  input  8  ASCII byte
- char_ready  output  1  console can accept a byte this cycle
- write_op  output  1  one-cycle write strobe to the display
- bus_addr  output  32  cell index = row*COLS+col, zero-extended
- bus_data  output  32  ASCII code of the cell, zero-extended {24'b0, code}
- cursor_col  output  8  current cursor column
- cursor_row  output  8  current cursor row
- busy  output  1  clear sequence in progress

Behaviour:
- Reset (async) values:
  - write_op=0, bus_addr=0, bus_data=0.
  - cursor (0,0), clear counter 0.
  - State is CLR_SCREEN if INIT_CLEAR=1, else IDLE.
- Reset during any clear aborts it. On release, the clear restarts from address 0.
- States:
  - IDLE: char_ready=1, busy=0.
  - CLR_LINE: char_ready=0, busy=1.
  - CLR_SCREEN: char_ready=0, busy=1.
- A byte is accepted when char_valid && char_ready at a posedge.
- All outputs are registered. For a byte accepted at edge N, write_op is high during the cycle after edge N. It is high for exactly 1 cycle per cell write.
- Printable 0x20..0x7E:
  - Write the code at (row,col).
  - If col<COLS-1, then col+1.
  - Else col=0 and do a row advance.
- CR 0x0D: col=0. No write.
- LF 0x0A: col=0 and do a row advance. No write of its own.
- BS 0x08:
  - If col>0: col-1, then write 0x20 at the new (row,col).
  - If col=0: no change and no write. There is no reverse wrap to the previous row.
- FF 0x0C: cursor (0,0), enter CLR_SCREEN.
- All other codes, 0x7F and 0x80..0xFF: consumed (ready stays high), no write, cursor unchanged.
- Row advance:
  - row = (row==ROWS-1) ? 0 : row+1. There is no readback, so there is no scrolling; the display wraps ring-style.
  - Then enter CLR_LINE for the new row.
  - The printable write that triggered a wrap is issued before the clear starts.
- CLR_LINE:
  - Writes 0x20 to addresses row*COLS+0 .. row*COLS+COLS-1 on consecutive cycles, one per cycle, ascending.
  - Returns to IDLE on the cycle after the last write.
  - The cursor sits at (row,0) throughout.
- CLR_SCREEN:
  - Writes 0x20 to addresses 0 .. COLS*ROWS-1 on consecutive cycles, ascending.
  - Returns to IDLE on the cycle after the last write. Cursor is (0,0).
- Clear counter width: $clog2(COLS*ROWS); it compares against the terminal value, never overflows.
- Address arithmetic is computed at full 32-bit width; no truncation is permitted.
- Back-to-back printable bytes in IDLE produce one write per cycle with no bubbles.
- char_data is ignored when char_valid=0 or char_ready=0; the source must hold it stable until accepted.

Decomposition:
- Shared package (defines.svh), new entries:
  - ASCII constants: SPACE 0x20, CR, LF, BS, FF.
  - Console_state_t enum {IDLE, CLR_LINE, CLR_SCREEN}.
  - Cursor typedefs.
- Existing Word_t and Bit_t are reused for the bus.
- One sub-module: vga_cursor. It holds the col/row registers and implements advance, carriage return, backspace and row-wrap, providing the wrap flag and row*COLS+col.
- The top holds the handshake, FSM, clear counter and output registers.

Test Plan:
- INIT_CLEAR=1, release rst → 3700 consecutive write_op pulses, addr 0..3699, data 0x20. char_ready=0 and busy=1 throughout, then ready=1 with cursor (0,0).
- In IDLE send 'A' (0x41) then 'B' → writes addr 0 data 0x41, then addr 1 data 0x42, on consecutive cycles. Cursor ends at col 2.
- Cursor (36,99), send 'Z' → write addr 3699 data 0x5A, then 100 writes of 0x20 to addr 0..99. Cursor ends at (0,0); ready is low for those 100 cycles.
- Cursor (3,5), send BS → one write addr 304 data 0x20, cursor (3,4). Cursor (3,0), send BS → no write, cursor unchanged.
- Send LF at (4,7) → clear addr 500..599, cursor (5,0). Send CR at (5,9) → no write, cursor (5,0). Send 0x07 → no write, accepted in 1 cycle.
- Send FF, assert rst after 1000 clear writes → outputs reset immediately. After release, a full clear restarts from addr 0.
